// File: rtl/ps2_defs.sv
// Shared definitions for the PS/2 host side: FSM encodings, command bytes
// and frame constants used by the transmitter and the packet receiver.
package ps2_defs;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_RTS       = 3'd2,
      ST_XFER      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } tx_state_e;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_SET_RATE = 8'hF3;
   localparam logic [7:0] ACK_BYTE     = 8'hFA;

   // Falling edges in a host-to-device frame: 8 data, parity, stop, line-ack.
   localparam int FRAME_FE = 11;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe
// derived only from the synchronized value.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic line_o,
   output logic fall_o
);

   // [0] metastable stage, [1] synchronized value, [2] previous synchronized value.
   // Reset to 1 so an idle (pulled-up) bus never produces a spurious edge.
   logic [2:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[1:0], line_i};
      end
   end

   assign line_o = sync_q[1];
   assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift
// out data/parity/stop on device clocks, then sample the device line-ack.
module ps2_host_tx
   import ps2_defs::*;
#(
   parameter int CLK_FREQ_HZ    = 50000000,
   parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10000,
   parameter int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1000) * 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       done,
   output logic       ack_ok,
   output logic       timeout_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       ACK_FE   = 4'(FRAME_FE - 1);

   logic clk_s, clk_fe;
   logic data_s, data_fall_unused;

   ps2_line_sync u_clk_sync (
      .clk    (clk),
      .rst    (rst),
      .line_i (ps2_clk_in),
      .line_o (clk_s),
      .fall_o (clk_fe)
   );

   ps2_line_sync u_data_sync (
      .clk    (clk),
      .rst    (rst),
      .line_i (ps2_data_in),
      .line_o (data_s),
      .fall_o (data_fall_unused)
   );

   tx_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       fe_cnt_q;
   logic [7:0]       shift_q;
   logic             parity_q;
   logic             cmd_ready_q, done_q, ack_ok_q, timeout_err_q;
   logic             clk_oe_q, data_oe_q;
   logic             timeout_hit;

   assign timeout_hit = (cnt_q == TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         fe_cnt_q      <= '0;
         shift_q       <= '0;
         parity_q      <= 1'b0;
         cmd_ready_q   <= 1'b1;
         done_q        <= 1'b0;
         ack_ok_q      <= 1'b0;
         timeout_err_q <= 1'b0;
         clk_oe_q      <= 1'b0;
         data_oe_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // The cycle carrying done keeps cmd_ready low; ready rises one cycle later.
               if (!cmd_ready_q) begin
                  cmd_ready_q <= 1'b1;
               end else if (cmd_valid) begin
                  shift_q       <= cmd_data;
                  parity_q      <= odd_parity(cmd_data);
                  ack_ok_q      <= 1'b0;
                  timeout_err_q <= 1'b0;
                  cnt_q         <= '0;
                  cmd_ready_q   <= 1'b0;
                  clk_oe_q      <= 1'b1;
                  state_q       <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (cnt_q == INH_LAST) begin
                  data_oe_q <= 1'b1;
                  state_q   <= ST_RTS;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RTS: begin
               // Release the clock with data still low: that is the start bit.
               clk_oe_q <= 1'b0;
               cnt_q    <= '0;
               fe_cnt_q <= '0;
               state_q  <= ST_XFER;
            end
            ST_XFER: begin
               if (timeout_hit) begin
                  clk_oe_q      <= 1'b0;
                  data_oe_q     <= 1'b0;
                  timeout_err_q <= 1'b1;
                  ack_ok_q      <= 1'b0;
                  done_q        <= 1'b1;
                  state_q       <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (clk_fe) begin
                     fe_cnt_q <= fe_cnt_q + 1'b1;
                     if (fe_cnt_q < 4'd8) begin
                        data_oe_q <= ~shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                     end else if (fe_cnt_q == 4'd8) begin
                        data_oe_q <= ~parity_q;
                     end else if (fe_cnt_q == 4'd9) begin
                        data_oe_q <= 1'b0;
                     end else if (fe_cnt_q == ACK_FE) begin
                        ack_ok_q <= ~data_s;
                        state_q  <= ST_WAIT_IDLE;
                     end
                  end
               end
            end
            ST_WAIT_IDLE: begin
               data_oe_q <= 1'b0;
               if (timeout_hit) begin
                  clk_oe_q      <= 1'b0;
                  timeout_err_q <= 1'b1;
                  ack_ok_q      <= 1'b0;
                  done_q        <= 1'b1;
                  state_q       <= ST_IDLE;
               end else if (clk_s && data_s) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               clk_oe_q  <= 1'b0;
               data_oe_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign done        = done_q;
   assign ack_ok      = ack_ok_q;
   assign timeout_err = timeout_err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on the open-drain pair and
// a scoreboard matching each done against the frame the device observed.
module tb_ps2_host_tx;
   import ps2_defs::*;

   localparam int INH = 50;
   localparam int TMO = 2000;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready, done, ack_ok, timeout_err;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       ps2_clk_line, ps2_data_line;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .CLK_FREQ_HZ    (500000),
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_data    (cmd_data),
      .cmd_ready   (cmd_ready),
      .done        (done),
      .ack_ok      (ack_ok),
      .timeout_err (timeout_err),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_data_in (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   typedef struct {
      logic [7:0] data;
      logic       ack;
      logic       tmo;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          dev_mode = 0;     // 0: acks, 1: no ack, 2: silent
   int          dev_half = 15;
   int          dev_fe = 0;
   bit          dev_busy = 1'b0;
   logic [10:0] dev_bits = '0;
   logic        prev_clk_oe = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Frame as the device should see it on its sampling points:
   // [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
   function automatic logic [10:0] ref_frame(input logic [7:0] b);
      logic [10:0] f;
      int ones;
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         if (b[i]) ones++;
      end
      f[9]  = (ones % 2 == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic dev_frame();
      dev_busy = 1'b1;
      dev_fe   = 0;
      repeat (dev_half) @(negedge clk);
      dev_bits[0] = ps2_data_line;
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1;
         dev_fe      = i;
         repeat (dev_half) @(negedge clk);
         dev_clk_low = 1'b0;
         dev_bits[i] = ps2_data_line;
         repeat (dev_half) @(negedge clk);
      end
      if (dev_mode == 0) dev_data_low = 1'b1;
      repeat (dev_half / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      dev_fe      = 11;
      repeat (dev_half) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (dev_half / 2) @(negedge clk);
      dev_data_low = 1'b0;
      dev_busy     = 1'b0;
   endtask

   // Device: a clock release with data held low is a request-to-send.
   initial begin
      forever begin
         @(negedge clk);
         if (prev_clk_oe && !ps2_clk_oe && ps2_data_oe && dev_mode != 2) dev_frame();
         prev_clk_oe = ps2_clk_oe;
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1, expected no transaction pending");
            end else begin
               e = exp_q.pop_front();
               check("ack_ok", 32'(ack_ok), 32'(e.ack));
               check("timeout_err", 32'(timeout_err), 32'(e.tmo));
               if (!e.tmo) check($sformatf("frame_%02h", e.data), 32'(dev_bits), 32'(ref_frame(e.data)));
               $display("txn data=%02h ack_ok=%0b timeout_err=%0b frame=%03h", e.data, ack_ok, timeout_err, dev_bits);
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_ready: got cmd_ready=%0b after 5000 cycles, expected 1", cmd_ready);
      end
   endtask

   task automatic issue(input logic [7:0] b, input int mode, input int half, input bit timing);
      exp_t e;
      int n;
      wait_ready();
      dev_mode = mode;
      dev_half = half;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = b;
      e.data = b;
      e.ack  = (mode == 0);
      e.tmo  = (mode == 2);
      exp_q.push_back(e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      cmd_data = $urandom_range(0, 255);
      if (timing) begin
         n = 0;
         @(negedge clk);
         while (ps2_clk_oe && !ps2_data_oe && n < INH + 10) begin
            n++;
            @(negedge clk);
         end
         check("inhibit_len", 32'(n), 32'(INH));
         check("rts_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'h3);
         @(negedge clk);
         check("xfer_start_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'h1);
      end
   endtask

   task automatic wait_done(output bit got);
      int n;
      n = 0;
      got = 1'b0;
      while (n < 5000) begin
         @(negedge clk);
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         n++;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL wait_done: got no done in 5000 cycles, expected one");
      end
   endtask

   task automatic finish_txn();
      bit got;
      wait_done(got);
      if (got) begin
         @(negedge clk);
         check("done_single_pulse", 32'(done), 32'h0);
         check("ready_after_done", 32'(cmd_ready), 32'h1);
      end
   endtask

   task automatic wait_dev_fe(input int target);
      int n;
      n = 0;
      while (dev_fe < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (dev_fe < target) begin
         checks++;
         errors++;
         $display("FAIL wait_dev_fe: got fe=%0d, expected %0d", dev_fe, target);
      end
   endtask

   initial begin
      bit got;
      int n;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      check("rst_outputs", 32'({done, ack_ok, timeout_err, ps2_clk_oe, ps2_data_oe}), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Enable command with inhibit/RTS timing, then parity extremes.
      issue(CMD_ENABLE, 0, 15, 1'b1);
      finish_txn();
      issue(8'h00, 0, 12, 1'b0);
      finish_txn();
      issue(8'hFF, 0, 12, 1'b0);
      finish_txn();
      issue(8'h01, 0, 12, 1'b0);
      finish_txn();

      // No line-ack from the device.
      issue(CMD_SET_RATE, 1, 14, 1'b0);
      finish_txn();

      // Silent device: timeout releases both lines.
      issue(CMD_RESET, 2, 10, 1'b0);
      wait_done(got);
      if (got) begin
         check("tmo_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
         check("tmo_ready_low", 32'(cmd_ready), 32'h0);
         @(negedge clk);
         check("tmo_ready_next", 32'(cmd_ready), 32'h1);
      end

      // Reset in the middle of a transfer.
      issue(CMD_ENABLE, 0, 15, 1'b0);
      wait_dev_fe(5);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
      check("midrst_ready", 32'(cmd_ready), 32'h1);
      void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (dev_busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check("midrst_no_done", 32'(done), 32'h0);
      issue(CMD_ENABLE, 0, 15, 1'b0);
      finish_txn();

      // Busy rejection: a new request mid-transfer must not disturb the frame.
      issue(CMD_ENABLE, 0, 15, 1'b0);
      wait_dev_fe(3);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = CMD_RESET;
      @(negedge clk);
      cmd_valid = 1'b0;
      finish_txn();

      // Randomized commands, acked or not, at varying device clock rates.
      for (int i = 0; i < 8; i++) begin
         issue(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), int'($urandom_range(8, 20)), 1'b0);
         finish_txn();
      end

      repeat (20) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse over the open-drain PS/2 clock/data pair. It performs the inhibit and request-to-send sequence, shifts out data, parity and stop bits on device-generated clocks, and checks the device line-ack. It sits beside the packet receiver, which decodes the mouse's reply (0xFA) and the movement packets feeding the axis/Z accumulation logic. The block only drives the lines low; the top level builds the tristate buffers.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency.
INHIBIT_CYCLES, 5000, cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum cycles from clock release to ack (15 ms at 50 MHz).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
cmd_valid  in  1  command request; accepted only when cmd_ready=1.
cmd_data  in  8  command byte; captured on acceptance.
cmd_ready  out  1  high in IDLE only.
done  out  1  one-cycle pulse at end of a transaction (success or failure).
ack_ok  out  1  valid with done: 1 = device acked (data low at ack bit).
timeout_err  out  1  valid with done: 1 = timeout expired.
ps2_clk_in  in  1  raw PS/2 clock line (asynchronous).
ps2_data_in  in  1  raw PS/2 data line (asynchronous).
ps2_clk_oe  out  1  1 = pull PS/2 clock low.
ps2_data_oe  out  1  1 = pull PS/2 data low.

Behaviour:
- Clocking: one clock (clk); reset rst is asynchronous and active-high.
- Reset: all outputs 0 except cmd_ready=1; state IDLE; counters 0. Both oe outputs drop to 0 immediately on rst assertion, including mid-transaction.
- Input conditioning: ps2_clk_in and ps2_data_in pass through 2-FF synchronizers. A falling edge (fe) is synchronized clk 1 then 0. Logic uses only the synchronized values.
- Acceptance: in IDLE, cmd_valid=1 latches cmd_data into the shift register, computes parity = ~^cmd_data (odd parity), and enters INHIBIT on the next cycle. cmd_valid while busy is ignored.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles.
- RTS: one cycle with ps2_clk_oe=1 and ps2_data_oe=1. The start bit is 0.
- XFER: ps2_clk_oe=0 and ps2_data_oe held at 1. A bit counter n counts fe events from 1 to 11, and the timeout counter starts at entry.
  - After fe n=1..8: drive bit n-1 of cmd_data, LSB first (oe = ~bit).
  - After fe 9: drive parity.
  - After fe 10: ps2_data_oe=0 (stop bit, line released).
  - At fe 11: sample synchronized data. Data = 0 sets ack_ok=1; data = 1 sets ack_ok=0.
  - Then go to WAIT_IDLE.
- WAIT_IDLE: both oe=0. Wait until synchronized clk=1 and data=1, then pulse done for one cycle and return to IDLE (cmd_ready=1 on the following cycle).
- Timeout: if the counter reaches TIMEOUT_CYCLES in XFER or WAIT_IDLE:
  - release both lines;
  - set timeout_err=1 and ack_ok=0;
  - pulse done;
  - go to IDLE. This takes priority over a coincident fe.
- ack_ok and timeout_err hold their value until the next acceptance, which clears both.
- An fe seen in INHIBIT or RTS is ignored, because the host is driving the clock.
- States: IDLE, INHIBIT, RTS, XFER, WAIT_IDLE. The state register is 3 bits, one-hot or binary.

Decomposition:
- Shared package/include ps2_defs:
  - state encodings;
  - command constants: CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_SET_RATE=8'hF3;
  - device reply constant: ACK_BYTE=8'hFA;
  - bit-count constant FRAME_FE=11.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detector. It is instantiated once per line and reused by the receiver.

Test Plan:
- Enable command: cmd_data=0xF4, device model clocks at 12.5 kHz and acks.
  - After 5000 cycles of clock-low, data bits sampled on rising edges are 0,0,1,0,1,1,1,1, then parity=0, then stop=1.
  - done pulses once, with ack_ok=1 and timeout_err=0.
- Parity extremes:
  - cmd_data=0x00 gives parity bit 1.
  - cmd_data=0xFF gives parity bit 1.
  - cmd_data=0x01 gives parity bit 0.
- No ack: the device leaves data high on clock 11. Expect done with ack_ok=0 and timeout_err=0.
- Silent device: the device never clocks after RTS. At TIMEOUT_CYCLES, expect both oe=0, done=1, timeout_err=1, and cmd_ready=1 on the next cycle.
- Reset mid-transfer: assert rst after fe 5. Expect both oe=0 in the same cycle, cmd_ready=1, and no done pulse. Then send 0xF4 normally and expect success.
- Busy rejection: pulse cmd_valid with 0xFF during XFER of 0xF4. Expect the transmitted bits to remain those of 0xF4 and exactly one done.
